game_ctrl_fsm: RTL and testbench
================================

Name: game_ctrl_fsm

Overview:
- Parametrised main game controller for the Tetris design. It owns the mode FSM, the controlled-piece registers, the stacked-board register and level progression.
- Generalises the fixed-size top-level game logic: board dimensions, lines-per-level and maximum level are parameters.
- Adds two behaviours: a timed GAME_OVER state, and level tracking driven by cleared lines.
- Sits between next_block/complete_row (inputs) and vga/block_fall/score_control (outputs).

Parameters:
- BOARD_W, 10, board width in blocks
- BOARD_H, 20, board height in blocks
- BLK_BITS, 3, piece-type code width (0 = empty)
- X_BITS, 4, x-position width
- Y_BITS, 5, y-position width
- ROT_BITS, 2, rotation width
- LINES_PER_LEVEL, 10, lines cleared per level step; must be >= 4
- MAX_LEVEL, 7, saturating top level
- OVER_HOLD, 200000000, cycles spent in GAME_OVER (2 s at 100 MHz)

Ports:
- clk_100MHz  in  1  system clock
- sw_rst_n  in  1  reset
- btn_start  in  1  one-pulse start/pause button
- random_blk  in  BLK_BITS  random piece for the first spawn
- next_blk  in  BLK_BITS  piece type for the next cycle, from next_block
- next_pos_x  in  X_BITS  next x position
- next_pos_y  in  Y_BITS  next y position
- next_rot  in  ROT_BITS  next rotation
- stacked_next  in  BOARD_W*BOARD_H  board after the lock and the row clear
- ctrl_overlap  in  1  controlled piece overlaps the stacked board
- lines_valid  in  1  one-cycle pulse: a clear occurred
- lines_cleared  in  3  rows cleared, 1..4; sampled only when lines_valid is high
- mode  out  2  0 = IDLE, 1 = PLAY, 2 = PAUSE, 3 = OVER
- ctrl_blk  out  BLK_BITS  controlled piece type
- ctrl_pos_x  out  X_BITS  controlled piece x position
- ctrl_pos_y  out  Y_BITS  controlled piece y position
- ctrl_rot  out  ROT_BITS  controlled piece rotation
- stacked_block  out  BOARD_W*BOARD_H  board; bit 0 is the top-left cell
- level  out  4  current level
- level_up  out  1  one-cycle pulse on a level increment
- game_start  out  1  one-cycle pulse on the IDLE->PLAY transition

Behaviour:
- Clock and reset: clock clk_100MHz. Reset sw_rst_n, asynchronous, active-low.
- Reset values:
  - mode = IDLE, ctrl_blk = 0, ctrl_pos_x = BOARD_W/2-1, ctrl_pos_y = 0, ctrl_rot = 0
  - stacked_block = 0, level = 0, level_up = 0, game_start = 0
  - internal lines_in_level = 0, over_cnt = 0
- Spawn values (S): x = BOARD_W/2-1, y = 0, rot = 0.
- IDLE:
  - Without btn_start: ctrl_blk = 0, position = S, board held.
  - With btn_start: go to PLAY next cycle; ctrl_blk <= random_blk; position = S; board cleared to 0; level = 0; lines_in_level = 0; game_start = 1 for exactly that cycle.
- PLAY, priority highest first:
  1. Game over (ctrl_pos_y == 0 && ctrl_overlap): go to OVER; ctrl_blk <= 0; board frozen; over_cnt <= 0. Game over beats btn_start in the same cycle.
  2. btn_start: go to PAUSE; all piece and board registers hold.
  3. Otherwise: ctrl_* <= next_*; stacked_block <= stacked_next.
- PAUSE:
  - All piece and board registers hold; lines_valid is ignored.
  - btn_start: go to PLAY and load next_* and stacked_next that cycle.
- OVER:
  - over_cnt increments each cycle; board is held for display.
  - When over_cnt == OVER_HOLD-1, go to IDLE.
  - btn_start is ignored in OVER.
- Illegal mode encoding: go to IDLE with the reset values of the ctrl registers; board holds.
- Level logic (PLAY only):
  - On lines_valid with n = lines_cleared: sum = lines_in_level + n.
  - If sum >= LINES_PER_LEVEL: lines_in_level <= sum - LINES_PER_LEVEL. If level < MAX_LEVEL, level increments and level_up pulses for 1 cycle.
  - Otherwise: lines_in_level <= sum.
  - At MAX_LEVEL, lines_in_level still wraps but level and level_up do not change.
  - lines_cleared == 0 or > 4 while lines_valid is high: no change.
- Latency: every output is registered and changes on the clock edge after the qualifying input.
- Reset mid-game: returns immediately to IDLE with all reset values.

Optional Feature:
- Macro GAME_CTRL_HOLD_PIECE_EN.
- When defined, adds ports:
  - hold_req  in  1  one-pulse hold request
  - hold_blk  out  BLK_BITS  held piece; 0 after reset and on game_start
- hold_req in PLAY, lowest priority, allowed only if no hold has occurred since the last spawn (y returned to 0 with a new piece):
  - If hold_blk == 0: hold_blk <= ctrl_blk; ctrl_blk <= next_blk; position = S.
  - Otherwise: swap ctrl_blk and hold_blk; position = S.
- A second hold_req before the next spawn is ignored.
- When the macro is undefined, the ports and logic are absent.

Test Plan:
- Reset, then btn_start with random_blk = 3 -> next cycle mode = 1, ctrl_blk = 3, ctrl_pos_x = 4, y = 0, stacked_block = 0, game_start pulses for 1 cycle.
- PLAY, btn_start, then next_pos_y changes for 50 cycles, then btn_start -> ctrl_pos_y frozen in PAUSE (mode = 2); next_pos_y is loaded on the resume cycle.
- PLAY, ctrl_pos_y = 0, ctrl_overlap = 1 and btn_start in the same cycle -> mode = 3 (not 2); with OVER_HOLD = 16, mode = 0 exactly 16 cycles later; btn_start during OVER has no effect.
- lines_valid pulses carrying 4, 4, 3 with LINES_PER_LEVEL = 10 -> level 0 -> 1 on the third pulse, level_up pulses once, lines_in_level = 1.
- Drive level to MAX_LEVEL = 7, then 10 more lines -> level stays 7, no level_up.
- With GAME_CTRL_HOLD_PIECE_EN: hold_req with ctrl_blk = 5, next_blk = 2 -> hold_blk = 5, ctrl_blk = 2; a second hold_req before the next spawn is ignored.

Source files
------------

// File: rtl/game_ctrl_fsm_if.sv
// Handshake bundle between the Tetris game controller and its neighbours.
// GAME_CTRL_HOLD_PIECE_EN adds the hold-piece request/response pair.
interface game_ctrl_fsm_if #(
    parameter int BOARD_W  = 10,
    parameter int BOARD_H  = 20,
    parameter int BLK_BITS = 3,
    parameter int X_BITS   = 4,
    parameter int Y_BITS   = 5,
    parameter int ROT_BITS = 2
);
    logic                         btn_start;
    logic [BLK_BITS-1:0]          random_blk;
    logic [BLK_BITS-1:0]          next_blk;
    logic [X_BITS-1:0]            next_pos_x;
    logic [Y_BITS-1:0]            next_pos_y;
    logic [ROT_BITS-1:0]          next_rot;
    logic [BOARD_W*BOARD_H-1:0]   stacked_next;
    logic                         ctrl_overlap;
    logic                         lines_valid;
    logic [2:0]                   lines_cleared;

    logic [1:0]                   mode;
    logic [BLK_BITS-1:0]          ctrl_blk;
    logic [X_BITS-1:0]            ctrl_pos_x;
    logic [Y_BITS-1:0]            ctrl_pos_y;
    logic [ROT_BITS-1:0]          ctrl_rot;
    logic [BOARD_W*BOARD_H-1:0]   stacked_block;
    logic [3:0]                   level;
    logic                         level_up;
    logic                         game_start;
`ifdef GAME_CTRL_HOLD_PIECE_EN
    logic                         hold_req;
    logic [BLK_BITS-1:0]          hold_blk;
`endif

    // master: upstream producers / downstream consumers; slave: the controller
    modport master (
        output btn_start, random_blk, next_blk, next_pos_x, next_pos_y, next_rot,
               stacked_next, ctrl_overlap, lines_valid, lines_cleared,
`ifdef GAME_CTRL_HOLD_PIECE_EN
        output hold_req,
        input  hold_blk,
`endif
        input  mode, ctrl_blk, ctrl_pos_x, ctrl_pos_y, ctrl_rot, stacked_block,
               level, level_up, game_start
    );

    modport slave (
        input  btn_start, random_blk, next_blk, next_pos_x, next_pos_y, next_rot,
               stacked_next, ctrl_overlap, lines_valid, lines_cleared,
`ifdef GAME_CTRL_HOLD_PIECE_EN
        input  hold_req,
        output hold_blk,
`endif
        output mode, ctrl_blk, ctrl_pos_x, ctrl_pos_y, ctrl_rot, stacked_block,
               level, level_up, game_start
    );
endinterface

// File: rtl/game_ctrl_fsm.sv
// Tetris main controller: mode FSM, controlled piece, stacked board, level tracking.
// Optional hold-piece support is compiled in with GAME_CTRL_HOLD_PIECE_EN.
module game_ctrl_fsm #(
    parameter int BOARD_W         = 10,
    parameter int BOARD_H         = 20,
    parameter int BLK_BITS        = 3,
    parameter int X_BITS          = 4,
    parameter int Y_BITS          = 5,
    parameter int ROT_BITS        = 2,
    parameter int LINES_PER_LEVEL = 10,
    parameter int MAX_LEVEL       = 7,
    parameter int OVER_HOLD       = 200000000
) (
    input  logic               clk_100MHz,
    input  logic               sw_rst_n,
    game_ctrl_fsm_if.slave     bus
);
    localparam int N        = BOARD_W * BOARD_H;
    localparam int LIL_BITS = $clog2(LINES_PER_LEVEL + 4);
    localparam int OC_BITS  = (OVER_HOLD > 1) ? $clog2(OVER_HOLD) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, PAUSE = 2'd2, OVER = 2'd3} mode_e;

    typedef struct packed {
        logic [BLK_BITS-1:0] blk;
        logic [X_BITS-1:0]   x;
        logic [Y_BITS-1:0]   y;
        logic [ROT_BITS-1:0] rot;
    } piece_t;

    localparam logic [X_BITS-1:0] SPAWN_X = X_BITS'(BOARD_W / 2 - 1);
    localparam piece_t SPAWN = {{BLK_BITS{1'b0}}, SPAWN_X, {Y_BITS{1'b0}}, {ROT_BITS{1'b0}}};

    mode_e                mode_q, mode_d;
    piece_t               piece_q, piece_d, next_piece;
    logic [N-1:0]         board_q, board_d;
    logic [3:0]           level_q, level_d;
    logic                 level_up_q, level_up_d;
    logic                 game_start_q, game_start_d;
    logic [LIL_BITS-1:0]  lil_q, lil_d, lil_sum;
    logic [OC_BITS-1:0]   over_cnt_q, over_cnt_d;
    logic                 lines_ok;
`ifdef GAME_CTRL_HOLD_PIECE_EN
    logic [BLK_BITS-1:0]  hold_blk_q, hold_blk_d;
    logic                 hold_used_q, hold_used_d;
`endif

    assign next_piece = {bus.next_blk, bus.next_pos_x, bus.next_pos_y, bus.next_rot};
    assign lines_ok   = bus.lines_valid && (bus.lines_cleared != 3'd0) && (bus.lines_cleared <= 3'd4);
    assign lil_sum    = lil_q + LIL_BITS'(bus.lines_cleared);

    always_ff @(posedge clk_100MHz or negedge sw_rst_n) begin
        if (!sw_rst_n) begin
            mode_q       <= IDLE;
            piece_q      <= SPAWN;
            board_q      <= '0;
            level_q      <= '0;
            level_up_q   <= 1'b0;
            game_start_q <= 1'b0;
            lil_q        <= '0;
            over_cnt_q   <= '0;
`ifdef GAME_CTRL_HOLD_PIECE_EN
            hold_blk_q   <= '0;
            hold_used_q  <= 1'b0;
`endif
        end else begin
            mode_q       <= mode_d;
            piece_q      <= piece_d;
            board_q      <= board_d;
            level_q      <= level_d;
            level_up_q   <= level_up_d;
            game_start_q <= game_start_d;
            lil_q        <= lil_d;
            over_cnt_q   <= over_cnt_d;
`ifdef GAME_CTRL_HOLD_PIECE_EN
            hold_blk_q   <= hold_blk_d;
            hold_used_q  <= hold_used_d;
`endif
        end
    end

    always_comb begin
        mode_d       = mode_q;
        piece_d      = piece_q;
        board_d      = board_q;
        level_d      = level_q;
        level_up_d   = 1'b0;
        game_start_d = 1'b0;
        lil_d        = lil_q;
        over_cnt_d   = over_cnt_q;
`ifdef GAME_CTRL_HOLD_PIECE_EN
        hold_blk_d   = hold_blk_q;
        hold_used_d  = hold_used_q;
`endif

        unique case (mode_q)
            IDLE: begin
                piece_d = SPAWN;
                if (bus.btn_start) begin
                    mode_d       = PLAY;
                    piece_d.blk  = bus.random_blk;
                    board_d      = '0;
                    level_d      = '0;
                    lil_d        = '0;
                    game_start_d = 1'b1;
`ifdef GAME_CTRL_HOLD_PIECE_EN
                    hold_blk_d   = '0;
                    hold_used_d  = 1'b0;
`endif
                end
            end

            PLAY: begin
                if (piece_q.y == '0 && bus.ctrl_overlap) begin
                    mode_d      = OVER;
                    piece_d.blk = '0;
                    over_cnt_d  = '0;
                end else if (bus.btn_start) begin
                    mode_d = PAUSE;
`ifdef GAME_CTRL_HOLD_PIECE_EN
                end else if (bus.hold_req && !hold_used_q) begin
                    // Swap into the hold slot; an empty slot pulls the upcoming piece instead.
                    hold_used_d = 1'b1;
                    hold_blk_d  = piece_q.blk;
                    piece_d     = SPAWN;
                    piece_d.blk = (hold_blk_q == '0) ? bus.next_blk : hold_blk_q;
                    board_d     = bus.stacked_next;
`endif
                end else begin
                    piece_d = next_piece;
                    board_d = bus.stacked_next;
`ifdef GAME_CTRL_HOLD_PIECE_EN
                    // A fresh spawn is the piece jumping back to the top row.
                    if (next_piece.y == '0 && piece_q.y != '0)
                        hold_used_d = 1'b0;
`endif
                end

                // Level counting runs even on the cycle the mode changes.
                if (lines_ok) begin
                    if (lil_sum >= LIL_BITS'(LINES_PER_LEVEL)) begin
                        lil_d = lil_sum - LIL_BITS'(LINES_PER_LEVEL);
                        if (level_q < 4'(MAX_LEVEL)) begin
                            level_d    = level_q + 4'd1;
                            level_up_d = 1'b1;
                        end
                    end else begin
                        lil_d = lil_sum;
                    end
                end
            end

            PAUSE: begin
                if (bus.btn_start) begin
                    mode_d  = PLAY;
                    piece_d = next_piece;
                    board_d = bus.stacked_next;
`ifdef GAME_CTRL_HOLD_PIECE_EN
                    if (next_piece.y == '0 && piece_q.y != '0)
                        hold_used_d = 1'b0;
`endif
                end
            end

            OVER: begin
                if (over_cnt_q == OC_BITS'(OVER_HOLD - 1))
                    mode_d = IDLE;
                else
                    over_cnt_d = over_cnt_q + OC_BITS'(1);
            end

            default: begin
                mode_d  = IDLE;
                piece_d = SPAWN;
            end
        endcase
    end

    assign bus.mode          = mode_q;
    assign bus.ctrl_blk      = piece_q.blk;
    assign bus.ctrl_pos_x    = piece_q.x;
    assign bus.ctrl_pos_y    = piece_q.y;
    assign bus.ctrl_rot      = piece_q.rot;
    assign bus.stacked_block = board_q;
    assign bus.level         = level_q;
    assign bus.level_up      = level_up_q;
    assign bus.game_start    = game_start_q;
`ifdef GAME_CTRL_HOLD_PIECE_EN
    assign bus.hold_blk      = hold_blk_q;
`endif
endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Directed-vector bench for game_ctrl_fsm with a short game-over hold (16 cycles).
module tb_game_ctrl_fsm;
    localparam logic [199:0] PAT_A = {10{20'hA5F0C}};
    localparam logic [199:0] PAT_B = {20{10'h3C5}};

    logic clk = 1'b0;
    logic rst_n;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    always #5 clk = ~clk;

    game_ctrl_fsm_if bus ();

    game_ctrl_fsm #(.OVER_HOLD(16)) dut (
        .clk_100MHz (clk),
        .sw_rst_n   (rst_n),
        .bus        (bus.slave)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_lines(input int n);
        bus.lines_valid   = 1'b1;
        bus.lines_cleared = 3'(n);
        tick();
        bus.lines_valid   = 1'b0;
        bus.lines_cleared = 3'd0;
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.btn_start     = 1'b0;
        bus.random_blk    = '0;
        bus.next_blk      = '0;
        bus.next_pos_x    = '0;
        bus.next_pos_y    = '0;
        bus.next_rot      = '0;
        bus.stacked_next  = '0;
        bus.ctrl_overlap  = 1'b0;
        bus.lines_valid   = 1'b0;
        bus.lines_cleared = 3'd0;
`ifdef GAME_CTRL_HOLD_PIECE_EN
        bus.hold_req      = 1'b0;
`endif
        #12;
        chk("rst_mode",  bus.mode, 0);
        chk("rst_blk",   bus.ctrl_blk, 0);
        chk("rst_x",     bus.ctrl_pos_x, 4);
        chk("rst_y",     bus.ctrl_pos_y, 0);
        chk("rst_rot",   bus.ctrl_rot, 0);
        chk("rst_board", bus.stacked_block, 0);
        chk("rst_level", bus.level, 0);
        chk("rst_lvup",  bus.level_up, 0);
        chk("rst_gs",    bus.game_start, 0);
        rst_n = 1'b1;

        // idle without start keeps an empty piece
        bus.random_blk = 3'd3;
        tick();
        chk("idle_mode", bus.mode, 0);
        chk("idle_blk",  bus.ctrl_blk, 0);

        // start: board cleared even though stacked_next is non-zero
        bus.btn_start    = 1'b1;
        bus.stacked_next = PAT_A;
        tick();
        bus.btn_start = 1'b0;
        chk("start_mode",  bus.mode, 1);
        chk("start_blk",   bus.ctrl_blk, 3);
        chk("start_x",     bus.ctrl_pos_x, 4);
        chk("start_y",     bus.ctrl_pos_y, 0);
        chk("start_board", bus.stacked_block, 0);
        chk("start_gs",    bus.game_start, 1);

        bus.next_blk = 3'd3; bus.next_pos_x = 4'd5; bus.next_pos_y = 5'd1; bus.next_rot = 2'd1;
        tick();
        chk("play_gs_off", bus.game_start, 0);
        chk("play_x",      bus.ctrl_pos_x, 5);
        chk("play_y",      bus.ctrl_pos_y, 1);
        chk("play_rot",    bus.ctrl_rot, 1);
        chk("play_board",  bus.stacked_block, PAT_A);

        // pause freezes everything; a clear pulse during pause is ignored
        bus.btn_start  = 1'b1;
        bus.next_pos_y = 5'd2;
        tick();
        bus.btn_start = 1'b0;
        chk("pause_mode", bus.mode, 2);
        chk("pause_y",    bus.ctrl_pos_y, 1);
        for (int i = 0; i < 50; i++) begin
            bus.next_pos_y   = 5'(i % 30 + 2);
            bus.stacked_next = PAT_B;
            if (i == 10) begin
                bus.lines_valid = 1'b1; bus.lines_cleared = 3'd4;
            end
            tick();
            bus.lines_valid = 1'b0; bus.lines_cleared = 3'd0;
        end
        chk("pause_hold_y",     bus.ctrl_pos_y, 1);
        chk("pause_hold_board", bus.stacked_block, PAT_A);
        chk("pause_hold_mode",  bus.mode, 2);

        bus.next_pos_y = 5'd9;
        bus.btn_start  = 1'b1;
        tick();
        bus.btn_start = 1'b0;
        chk("resume_mode",  bus.mode, 1);
        chk("resume_y",     bus.ctrl_pos_y, 9);
        chk("resume_board", bus.stacked_block, PAT_B);

        // 4+4+3 = 11 -> level 1, one line carried over
        pulse_lines(4); chk("lv_a", bus.level, 0);
        pulse_lines(4); chk("lv_b", bus.level, 0);
        pulse_lines(3); chk("lv_c", bus.level, 1); chk("lvup_c", bus.level_up, 1);
        tick();         chk("lvup_c_off", bus.level_up, 0);
        // 5 and 0 are ignored; 1+4+4 = 9 stays, +1 -> level 2
        pulse_lines(5);
        pulse_lines(0);
        pulse_lines(4);
        pulse_lines(4); chk("lv_d", bus.level, 1); chk("lvup_d", bus.level_up, 0);
        pulse_lines(1); chk("lv_e", bus.level, 2); chk("lvup_e", bus.level_up, 1);

        for (int g = 0; g < 5; g++) begin
            pulse_lines(4);
            pulse_lines(4);
            pulse_lines(2);
            chk($sformatf("lv_step%0d", g), bus.level, g + 3);
            chk($sformatf("lvup_step%0d", g), bus.level_up, 1);
        end
        pulse_lines(4); chk("max_up_a", bus.level_up, 0);
        pulse_lines(4); chk("max_up_b", bus.level_up, 0);
        pulse_lines(2); chk("max_up_c", bus.level_up, 0);
        chk("max_level", bus.level, 7);

`ifdef GAME_CTRL_HOLD_PIECE_EN
        bus.next_blk = 3'd5; bus.next_pos_y = 5'd3;
        tick();
        chk("hold_pre_blk", bus.ctrl_blk, 5);
        bus.hold_req = 1'b1; bus.next_blk = 3'd2;
        tick();
        chk("hold_blk",  bus.hold_blk, 5);
        chk("hold_ctrl", bus.ctrl_blk, 2);
        chk("hold_y",    bus.ctrl_pos_y, 0);
        bus.next_blk = 3'd6; bus.next_pos_y = 5'd4;
        tick();
        bus.hold_req = 1'b0;
        chk("hold2_blk",  bus.hold_blk, 5);
        chk("hold2_ctrl", bus.ctrl_blk, 6);
`endif

        // game over beats a simultaneous start press
        bus.next_pos_y = 5'd0;
        tick();
        chk("go_pre_y", bus.ctrl_pos_y, 0);
        bus.ctrl_overlap = 1'b1;
        bus.btn_start    = 1'b1;
        bus.stacked_next = PAT_A;
        tick();
        bus.btn_start = 1'b0;
        chk("go_mode",  bus.mode, 3);
        chk("go_blk",   bus.ctrl_blk, 0);
        chk("go_board", bus.stacked_block, PAT_B);
        for (int i = 0; i < 15; i++) begin
            bus.btn_start = (i % 4 == 1);
            tick();
            chk($sformatf("over_c%0d", i + 1), bus.mode, 3);
        end
        bus.btn_start = 1'b1;
        tick();
        bus.btn_start = 1'b0;
        chk("over_exit_mode",  bus.mode, 0);
        chk("over_exit_board", bus.stacked_block, PAT_B);
        chk("over_exit_level", bus.level, 7);
        bus.ctrl_overlap = 1'b0;
        tick();
        chk("idle2_mode", bus.mode, 0);
        chk("idle2_blk",  bus.ctrl_blk, 0);

        bus.random_blk = 3'd6;
        bus.btn_start  = 1'b1;
        tick();
        bus.btn_start = 1'b0;
        chk("restart_mode",  bus.mode, 1);
        chk("restart_blk",   bus.ctrl_blk, 6);
        chk("restart_level", bus.level, 0);
        chk("restart_board", bus.stacked_block, 0);
        chk("restart_gs",    bus.game_start, 1);
`ifdef GAME_CTRL_HOLD_PIECE_EN
        chk("restart_hold",  bus.hold_blk, 0);
`endif

        // asynchronous reset mid-cycle
        bus.next_pos_y = 5'd3;
        tick();
        chk("mid_y", bus.ctrl_pos_y, 3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_mode",  bus.mode, 0);
        chk("arst_blk",   bus.ctrl_blk, 0);
        chk("arst_x",     bus.ctrl_pos_x, 4);
        chk("arst_y",     bus.ctrl_pos_y, 0);
        chk("arst_board", bus.stacked_block, 0);
        chk("arst_level", bus.level, 0);
        rst_n = 1'b1;
        tick();
        chk("arst_idle", bus.mode, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
